// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter that shares one RAM port among NUM_REQ requesters using a fixed
// IDLE/SETUP/ACCESS/DONE sequence. Define RAM_ARB_PRIORITY_EN to give requester 0 absolute priority.
module dp_ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic                          ram_oe,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [NUM_REQ-1:0] AckLsb = NUM_REQ'(1);
`ifdef RAM_ARB_PRIORITY_EN
  localparam int unsigned NumSlots = NUM_REQ - 1;
`else
  localparam int unsigned NumSlots = NUM_REQ;
`endif

  state_e                  state_q;
  logic [ID_W-1:0]         last_q;
  logic [ID_W-1:0]         grant_id_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    ram_cs_q;
  logic                    ram_we_q;
  logic                    ram_oe_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [DATA_WIDTH-1:0]   ram_wdata_q;

  logic                    win_valid;
  logic [ID_W-1:0]         win_id;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;

  // Requester index reached by stepping offs slots past base in the rotation.
  function automatic logic [ID_W-1:0] rr_slot(input int unsigned base, input int unsigned offs);
`ifdef RAM_ARB_PRIORITY_EN
    // Rotation covers 1..NUM_REQ-1 only; base never holds 0 in this build.
    return ID_W'(1 + (base + NUM_REQ - 2 + offs) % (NUM_REQ - 1));
`else
    return ID_W'((base + offs) % NUM_REQ);
`endif
  endfunction

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    // Walk farthest to nearest so the nearest pending requester after last_q wins.
    for (int unsigned k = NumSlots; k >= 1; k--) begin
      if (req[rr_slot(32'(last_q), k)]) begin
        win_valid = 1'b1;
        win_id    = rr_slot(32'(last_q), k);
      end
    end
`ifdef RAM_ARB_PRIORITY_EN
    if (req[0]) begin
      win_valid = 1'b1;
      win_id    = '0;
    end
`endif
  end

  assign win_addr  = req_addr[32'(win_id) * ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = req_wdata[32'(win_id) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= ID_W'(NUM_REQ - 1);
      grant_id_q  <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= '0;
          if (win_valid) begin
            grant_id_q <= win_id;
            we_q       <= req_we[win_id];
            wdata_q    <= win_wdata;
            ram_addr_q <= win_addr;
            ram_cs_q   <= 1'b1;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          ram_cs_q <= 1'b1;
          if (we_q) begin
            ram_we_q    <= 1'b1;
            ram_wdata_q <= wdata_q;
          end else begin
            ram_oe_q <= 1'b1;
          end
          state_q <= StAccess;
        end
        StAccess: begin
          // RAM output is combinational, so read data is valid at the edge leaving ACCESS.
          if (!we_q) begin
            rdata_q <= ram_rdata;
          end
          ram_cs_q    <= 1'b0;
          ram_we_q    <= 1'b0;
          ram_oe_q    <= 1'b0;
          ram_wdata_q <= '0;
          ack_q       <= AckLsb << grant_id_q;
          state_q     <= StDone;
        end
        StDone: begin
          ack_q <= '0;
`ifdef RAM_ARB_PRIORITY_EN
          if (grant_id_q != '0) begin
            last_q <= grant_id_q;
          end
`else
          last_q <= grant_id_q;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != StIdle);
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Bench for dp_ram_port_arbiter: directed vector table, corner-case sequences and random traffic
// checked every cycle against a transaction-level reference model.
module tb_dp_ram_port_arbiter;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            ram_init  = 1'b1;
  logic [N-1:0]    req       = '0;
  logic [N-1:0]    req_we    = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic            ram_cs;
  logic            ram_we;
  logic            ram_oe;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  always #5 clk = ~clk;

  dp_ram_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REQ   (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .grant_id (grant_id),
    .busy     (busy),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Asynchronous SRAM: combinational read, write at the clock edge while cs & we.
  logic [DW-1:0] ram_mem [256];
  assign ram_rdata = (ram_cs && ram_oe) ? ram_mem[ram_addr] : 8'hEE;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_cs && ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
  end

  // Reference model: one transaction at a time, phases counted from the grant edge.
  int         edge_n  = 0;
  int         m_last  = int'(N) - 1;
  int         m_next  = 0;
  int         m_g     = 0;
  int         m_id    = 0;
  int         m_grant = 0;
  bit         m_act   = 1'b0;
  bit         m_we    = 1'b0;
  logic [7:0] m_addr  = '0;
  logic [7:0] m_wd    = '0;
  logic [7:0] m_rd    = '0;
  logic [7:0] m_rdata = '0;
  logic [7:0] ref_mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
  endfunction

  function automatic int m_pick(input logic [N-1:0] r);
    int id = -1;
`ifdef RAM_ARB_PRIORITY_EN
    if (r[0]) id = 0;
    for (int k = 1; k < int'(N) && id < 0; k++) begin
      int c = 1 + (m_last - 1 + k) % (int'(N) - 1);
      if (r[c]) id = c;
    end
`else
    for (int k = 1; k <= int'(N) && id < 0; k++) begin
      int c = (m_last + k) % int'(N);
      if (r[c]) id = c;
    end
`endif
    return id;
  endfunction

  // Advance one clock: update the model from inputs seen at this edge, then check all outputs.
  task automatic step();
    int id;
    int ph;
    if (m_act && edge_n == m_g + 2) begin
      if (m_we) ref_mem[m_addr] = m_wd;
      else if (!rst) m_rdata = m_rd;
    end
    if (rst) begin
      m_act   = 1'b0;
      m_last  = int'(N) - 1;
      m_next  = edge_n + 1;
      m_rdata = '0;
      m_grant = 0;
    end else if (edge_n >= m_next && req != '0) begin
      id      = m_pick(req);
      m_act   = 1'b1;
      m_g     = edge_n;
      m_id    = id;
      m_grant = id;
      m_we    = req_we[id];
      m_addr  = req_addr[id*AW +: AW];
      m_wd    = req_wdata[id*DW +: DW];
      m_rd    = ref_mem[m_addr];
`ifdef RAM_ARB_PRIORITY_EN
      if (id != 0) m_last = id;
`else
      m_last = id;
`endif
      m_next = edge_n + 4;
    end
    @(posedge clk);
    #1;
    ph = m_act ? edge_n - m_g : 99;
    chk("busy", 32'(busy), 32'(ph <= 2));
    chk("ram_cs", 32'(ram_cs), 32'(ph <= 1));
    chk("ram_we", 32'(ram_we), 32'(ph == 1 && m_we));
    chk("ram_oe", 32'(ram_oe), 32'(ph == 1 && !m_we));
    chk("ack", 32'(ack), (ph == 2) ? (32'd1 << m_id) : 32'd0);
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    if (ph <= 1) chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    if (ph == 1 && m_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_wd));
    edge_n++;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic set_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Step until some ack appears; an expired budget counts as a failed comparison.
  task automatic wait_ack(input int budget, output int id, output int e);
    id = -1;
    e  = -1;
    for (int c = 0; c < budget && id < 0; c++) begin
      step();
      for (int i = 0; i < int'(N); i++) if (ack[i]) id = i;
      if (id >= 0) e = edge_n;
    end
    if (id < 0) begin
      n_chk++;
      $display("FAIL ack_timeout at edge %0d: got no ack, expected one within %0d cycles",
               edge_n, budget);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       req0;
    logic       we0;
    logic [7:0] addr0;
    logic [7:0] wd0;
    logic [3:0] e_ack;
    logic       e_busy;
    logic       e_cs;
    logic       e_we;
    logic       e_oe;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t tbl [9];
  int   gap [N];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int e;
    int prev_e;
    int exp_rr [5];
    int exp_alt [4];

    // Requester 0 writes 0xA5 to 0x10, then reads it back.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    exp_rr = '{0, 1, 2, 3, 0};
`ifdef RAM_ARB_PRIORITY_EN
    exp_alt = '{0, 0, 0, 0};
`else
    exp_alt = '{0, 2, 0, 2};
`endif

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    rst      = 1'b1;
    ram_init = 1'b1;
    step();
    ram_init = 1'b0;

    for (int r = 0; r < 9; r++) begin
      rst               = tbl[r].rst;
      req               = {3'b000, tbl[r].req0};
      req_we[0]         = tbl[r].we0;
      req_addr[AW-1:0]  = tbl[r].addr0;
      req_wdata[DW-1:0] = tbl[r].wd0;
      step();
      chk("tbl_ack", 32'(ack), 32'(tbl[r].e_ack));
      chk("tbl_busy", 32'(busy), 32'(tbl[r].e_busy));
      chk("tbl_cs", 32'(ram_cs), 32'(tbl[r].e_cs));
      chk("tbl_we", 32'(ram_we), 32'(tbl[r].e_we));
      chk("tbl_oe", 32'(ram_oe), 32'(tbl[r].e_oe));
      chk("tbl_rdata", 32'(rdata), 32'(tbl[r].e_rdata));
      chk("tbl_grant", 32'(grant_id), 32'd0);
      if (tbl[r].e_cs) chk("tbl_addr", 32'(ram_addr), 32'h10);
      if (tbl[r].e_we) chk("tbl_wdata", 32'(ram_wdata), 32'hA5);
      if (tbl[r].rst) begin
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_wdata", 32'(ram_wdata), 32'h0);
      end
    end
    rst = 1'b0;
    drain();

    // All four requesting continuously from reset.
    do_reset();
    for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, 8'(8'h20 + i), 8'h00);
    prev_e = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(8, id, e);
      chk("rr_order", 32'(id), 32'(exp_rr[k]));
      if (k > 0) chk("rr_spacing", 32'(e - prev_e), 32'd4);
      prev_e = e;
    end
    drain();

    // last=1 with req1 and req3 pending: 3 is granted before 1.
    do_reset();
    set_req(1, 1'b0, 8'h01, 8'h00);
    wait_ack(8, id, e);
    chk("last1_setup", 32'(id), 32'd1);
    req = '0;
    step();
    set_req(1, 1'b0, 8'h02, 8'h00);
    set_req(3, 1'b0, 8'h03, 8'h00);
    wait_ack(8, id, e);
    chk("rr_13_first", 32'(id), 32'd3);
    wait_ack(8, id, e);
    chk("rr_13_second", 32'(id), 32'd1);
    drain();

    // req0 and req2 held together.
    do_reset();
    set_req(0, 1'b0, 8'h04, 8'h00);
    set_req(2, 1'b0, 8'h05, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_ack(8, id, e);
      chk("pair_order", 32'(id), 32'(exp_alt[k]));
    end
    drain();

    // Reset during the ACCESS cycle of a write by requester 1 (last=2 beforehand).
    do_reset();
    set_req(2, 1'b1, 8'h40, 8'h11);
    wait_ack(8, id, e);
    chk("pre_rst_id", 32'(id), 32'd2);
    req = '0;
    step();
    set_req(1, 1'b1, 8'h33, 8'h77);
    step();
    chk("pre_rst_grant", 32'(grant_id), 32'd1);
    step();
    chk("pre_rst_we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = '0;
    chk("rst_cs", 32'(ram_cs), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_oe", 32'(ram_oe), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    step();
    chk("rst_no_ack", 32'(ack), 32'd0);
    set_req(0, 1'b0, 8'h33, 8'h00);
    set_req(3, 1'b0, 8'h34, 8'h00);
    wait_ack(8, id, e);
    chk("post_rst_id", 32'(id), 32'd0);
    chk("post_rst_rdata", 32'(rdata), 32'h77);
    drain();

    // req2 dropped during SETUP still completes, and only once.
    do_reset();
    set_req(2, 1'b0, 8'h05, 8'h00);
    step();
    req = '0;
    step();
    step();
    chk("drop_ack", 32'(ack), 32'h4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_ack_once", 32'(ack), 32'd0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < int'(N); i++) gap[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req[i]) begin
          if (ack[i] || $urandom_range(0, 40) == 0) begin
            req[i] = 1'b0;
            gap[i] = $urandom_range(0, 3);
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if ($urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        end
      end
      rst = ($urandom_range(0, 300) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
